// File: rtl/kyber_decenc_phase_ctrl.sv
// Phase sequencer for the Kyber encapsulation/decapsulation datapath: steps
// through the ENC or DEC phase list, launches each unit, and watches for hangs.
module kyber_decenc_phase_ctrl #(
  parameter logic [15:0] TIMEOUT = 16'd8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        enc_dec_sel,
  input  logic        abort,
  input  logic [11:0] phase_done,
  output logic [3:0]  cstate,
  output logic        mux_enc_dec,
  output logic [11:0] phase_start,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // state | meaning
  // IDLE     | no operation running
  // UNPACK   | unpack input operands
  // NTT      | forward NTT
  // PACC     | pointwise multiply-accumulate
  // INTT     | inverse NTT
  // SUB      | subtraction (DEC only)
  // REDUCE   | modular reduction
  // TO_MSG   | decode to message (DEC final)
  // FROM_MSG | encode message (ENC only)
  // HASH     | hashing (ENC only)
  // ADD      | addition (ENC only)
  // PACK     | pack ciphertext (ENC final)
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    UNPACK   = 4'd1,
    NTT      = 4'd2,
    PACC     = 4'd3,
    INTT     = 4'd4,
    SUB      = 4'd5,
    REDUCE   = 4'd6,
    TO_MSG   = 4'd7,
    FROM_MSG = 4'd8,
    HASH     = 4'd9,
    ADD      = 4'd10,
    PACK     = 4'd11
  } phase_t;

  localparam logic [15:0] WD_LAST = TIMEOUT - 16'd1;

  phase_t      state;
  phase_t      nxt;
  logic [15:0] wd;
  logic [15:0] done_ext;
  logic        entry;
  logic        cur_done;
  logic        wd_expired;

  function automatic phase_t next_phase(input phase_t p, input logic dec);
    case (p)
      UNPACK:   return dec ? NTT : HASH;
      HASH:     return NTT;
      NTT:      return PACC;
      PACC:     return INTT;
      INTT:     return dec ? SUB : FROM_MSG;
      SUB:      return REDUCE;
      REDUCE:   return dec ? TO_MSG : PACK;
      FROM_MSG: return ADD;
      ADD:      return REDUCE;
      default:  return IDLE;
    endcase
  endfunction

  // The launch pulse marks the entry cycle; completion and timeout are only
  // honoured after it, so the watchdog counts eligible cycles only.
  assign done_ext   = {4'b0000, phase_done};
  assign entry      = |phase_start;
  assign cur_done   = done_ext[state] & ~entry;
  assign wd_expired = ~entry & (wd == WD_LAST);
  assign cstate     = state;

  always_comb begin
    nxt = IDLE;
    nxt = next_phase(state, mux_enc_dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mux_enc_dec <= 1'b0;
      phase_start <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      wd          <= '0;
    end else begin
      phase_start <= '0;
      done        <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state       <= UNPACK;
          mux_enc_dec <= enc_dec_sel;
          phase_start <= 12'd1 << UNPACK;
          busy        <= 1'b1;
          err         <= 1'b0;
          wd          <= '0;
        end
      end else if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        wd    <= '0;
      end else if (cur_done) begin
        wd <= '0;
        if (nxt == IDLE) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state       <= nxt;
          phase_start <= 12'd1 << nxt;
        end
      end else if (wd_expired) begin
        state <= IDLE;
        busy  <= 1'b0;
        err   <= 1'b1;
        wd    <= '0;
      end else if (!entry) begin
        wd <= wd + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_kyber_decenc_phase_ctrl.sv
// Scoreboard bench for the phase sequencer: stimulus pushes expected phase
// events, a monitor pops and compares them as the DUT presents them.
module tb_kyber_decenc_phase_ctrl;

  localparam int K_START = 1;
  localparam int K_DONE  = 2;
  localparam int K_IDLE  = 3;

  typedef struct {
    int   kind;
    int   cs;
    logic mux;
    logic err;
    int   gap;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        enc_dec_sel = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] resp_done = '0;
  logic [11:0] man_done = '0;
  logic [11:0] phase_done;
  logic [3:0]  cstate;
  logic        mux_enc_dec;
  logic [11:0] phase_start;
  logic        busy;
  logic        done;
  logic        err;

  int  checks = 0;
  int  passes = 0;
  int  cyc = 0;
  int  last_ev_cyc = 0;
  int  done_cyc = 0;
  ev_t exp_q[$];

  int  auto_en = 0;
  int  resp_delay = 3;
  int  hang = -1;

  assign phase_done = resp_done | man_done;

  kyber_decenc_phase_ctrl #(.TIMEOUT(16'd16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .enc_dec_sel(enc_dec_sel),
    .abort(abort), .phase_done(phase_done), .cstate(cstate),
    .mux_enc_dec(mux_enc_dec), .phase_start(phase_start), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push(input int k, input int cs, input logic m, input logic e, input int g);
    ev_t ev;
    ev.kind = k; ev.cs = cs; ev.mux = m; ev.err = e; ev.gap = g;
    exp_q.push_back(ev);
  endtask

  // Unit model: answers each launch after resp_delay cycles unless that phase hangs.
  initial begin
    int   cnt;
    int   cur;
    logic pending;
    pending = 1'b0; cnt = 0; cur = 0;
    forever begin
      @(negedge clk);
      resp_done = '0;
      if (!rst_n) begin
        pending = 1'b0;
      end else begin
        if (phase_start != 0 && auto_en != 0) begin
          pending = 1'b1; cnt = resp_delay; cur = int'(cstate);
        end else if (pending && cnt > 0) begin
          cnt--;
        end
        if (pending && cnt == 0) begin
          if (cur != hang) resp_done = 12'd1 << cur;
          pending = 1'b0;
        end
      end
    end
  end

  // Monitor: every launch pulse, done pulse or drop of busy is an event.
  initial begin
    logic        prev_busy;
    logic [11:0] prev_ps;
    int          kind;
    ev_t         e;
    logic [20:0] act_v;
    logic [20:0] req_v;
    logic [11:0] req_ps;
    prev_busy = 1'b0; prev_ps = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0; prev_ps = '0;
      end else begin
        kind = 0;
        if (phase_start != 0) kind = K_START;
        else if (done) kind = K_DONE;
        else if (prev_busy && !busy) kind = K_IDLE;
        if (kind != 0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_event", 64'(kind), 64'(0));
          end else begin
            e = exp_q.pop_front();
            req_ps = (e.kind == K_START) ? (12'd1 << e.cs) : 12'd0;
            act_v = {2'(kind), cstate, phase_start, mux_enc_dec, err, busy};
            req_v = {2'(e.kind), (e.kind == K_START) ? 4'(e.cs) : 4'd0, req_ps,
                     e.mux, e.err, e.kind == K_START};
            chk("event", 64'(act_v), 64'(req_v));
            if (kind == K_START) chk("single_cycle_start", 64'(prev_ps), 64'(0));
            if (e.gap >= 0) chk("event_gap", 64'(cyc - last_ev_cyc), 64'(e.gap));
          end
          last_ev_cyc = cyc;
          if (kind == K_DONE) done_cyc = cyc;
        end
        prev_busy = busy; prev_ps = phase_start;
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, 64'(n < 300), 64'(1));
  endtask

  task automatic issue_start(input logic sel, input logic ab, output int t);
    @(posedge clk); #1;
    start = 1'b1; enc_dec_sel = sel; abort = ab;
    t = cyc;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_state(input int cs, input string name);
    int n;
    n = 0;
    while (!(cstate == 4'(cs) && phase_start != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 64'(n < 200), 64'(1));
  endtask

  initial begin
    int t;
    int dec_seq[7] = '{1, 2, 3, 4, 5, 6, 7};
    int enc_seq[10] = '{1, 9, 2, 3, 4, 8, 10, 6, 11, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({cstate, mux_enc_dec, phase_start, busy, done, err}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // DEC run, each unit answers 3 cycles after launch
    auto_en = 1; resp_delay = 3; hang = -1;
    for (int i = 0; i < 7; i++) push(K_START, dec_seq[i], 1'b1, 1'b0, (i == 0) ? -1 : 4);
    push(K_DONE, 0, 1'b1, 1'b0, 4);
    issue_start(1'b1, 1'b0, t);
    drain("dec_drain");
    chk("dec_done_latency", 64'(done_cyc - t), 64'(29));
    chk("mux_holds_after_done", 64'(mux_enc_dec), 64'(1));

    // Timeout in NTT, then recovery clears err
    hang = 2;
    push(K_START, 1, 1'b1, 1'b0, -1);
    push(K_START, 2, 1'b1, 1'b0, 4);
    push(K_IDLE, 0, 1'b1, 1'b1, 17);
    issue_start(1'b1, 1'b0, t);
    drain("timeout_drain");
    chk("err_sticky_idle", 64'({err, done, busy}), 64'(3'b100));
    hang = -1;
    for (int i = 0; i < 7; i++) push(K_START, dec_seq[i], 1'b1, 1'b0, (i == 0) ? -1 : 4);
    push(K_DONE, 0, 1'b1, 1'b0, 4);
    issue_start(1'b1, 1'b0, t);
    drain("recover_drain");

    // Boundary events in Unpack, then abort in PAcc coincident with its done
    auto_en = 0;
    push(K_START, 1, 1'b1, 1'b0, -1);
    push(K_START, 2, 1'b1, 1'b0, 17);
    push(K_START, 3, 1'b1, 1'b0, 2);
    push(K_IDLE, 0, 1'b1, 1'b0, 2);
    @(posedge clk); #1;
    start = 1'b1; enc_dec_sel = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; enc_dec_sel = 1'b0; man_done = 12'h002;
    @(posedge clk); #1;
    start = 1'b0; man_done = 12'h020;
    repeat (15) @(posedge clk);
    #1;
    man_done = 12'h002;
    @(posedge clk); #1;
    man_done = 12'h000;
    auto_en = 1; resp_delay = 1;
    wait_state(3, "reach_pacc");
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    auto_en = 0;
    drain("abort_drain");

    // Abort while idle does nothing
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_abort_ignored", 64'({cstate, busy, phase_start}), 64'(0));

    // Start with abort while idle is accepted; reset lands mid-INTT
    auto_en = 1; resp_delay = 1;
    push(K_START, 1, 1'b1, 1'b0, -1);
    push(K_START, 2, 1'b1, 1'b0, 2);
    push(K_START, 3, 1'b1, 1'b0, 2);
    issue_start(1'b1, 1'b1, t);
    wait_state(4, "reach_intt");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({cstate, mux_enc_dec, phase_start, busy, done, err}), 64'(0));
    chk("reset_queue_consumed", 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ENC run with immediate completions, first start after reset
    resp_delay = 1;
    for (int i = 0; i < 9; i++) push(K_START, enc_seq[i], 1'b0, 1'b0, (i == 0) ? -1 : 2);
    push(K_DONE, 0, 1'b0, 1'b0, 2);
    issue_start(1'b0, 1'b0, t);
    drain("enc_drain");
    chk("enc_done_latency", 64'(done_cyc - t), 64'(19));

    repeat (3) @(posedge clk);
    chk("queue_empty_end", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/kyber_decenc_phase_ctrl.md
KYBER_DECENC_PHASE_CTRL -- requirements
Module: kyber_decenc_phase_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 16'd8192, maximum cycles any single phase may stay active before it is declared hung.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 start  in  1  request to run one full operation; sampled only while busy=0.
REQ-005 enc_dec_sel  in  1  operation select: 0=ENC, 1=DEC; sampled with start.
REQ-006 abort  in  1  synchronous cancel of the running operation.
REQ-007 phase_done  in  12  per-phase completion strobes, indexed by phase code (bit 0 unused).
REQ-008 cstate  out  4  current phase code, driving the BRAM port multiplexers.
REQ-009 mux_enc_dec  out  1  latched operation select, driving the BRAM port multiplexers.
REQ-010 phase_start  out  12  one-hot, one-cycle launch pulse for the phase unit, indexed by phase code.
REQ-011 busy  out  1  high while any phase is active.
REQ-012 done  out  1  one-cycle pulse when an operation completes normally.
REQ-013 err  out  1  sticky flag set when a phase times out.

Function
REQ-014 Phase codes: IDLE=0, Unpack=1, NTT=2, PAcc=3, INTT=4, Sub=5, Reduce=6, To_Msg=7, From_Msg=8, Hash=9, Add=10, Pack=11; codes 12-15 never appear on cstate.
REQ-015 DEC sequence: IDLE, Unpack, NTT, PAcc, INTT, Sub, Reduce, To_Msg, then IDLE.
REQ-016 ENC sequence: IDLE, Unpack, Hash, NTT, PAcc, INTT, From_Msg, Add, Reduce, Pack, then IDLE.
REQ-017 Start acceptance: start=1 at cycle t with busy=0 produces, at t+1, cstate=1 (Unpack), mux_enc_dec=enc_dec_sel(t), busy=1, phase_start[1]=1.
REQ-018 start while busy=1 is ignored; mux_enc_dec is constant for the whole operation.
REQ-019 Every phase entry asserts phase_start[cstate] for exactly the first cycle of that phase; all other phase_start bits stay 0.
REQ-020 phase_done[cstate] is sampled only from the second cycle of a phase onward; a done on the entry cycle is ignored.
REQ-021 phase_done bits other than phase_done[cstate] are ignored at all times.
REQ-022 phase_done[cstate]=1 at cycle u advances the sequence, so that at u+1 cstate holds the next phase and its start pulse is asserted; per-phase overhead is exactly 1 cycle.
REQ-023 Completion: done of the last phase (To_Msg or Pack) at u produces, at u+1, cstate=0, busy=0, done=1 (one cycle only); mux_enc_dec holds its value.
REQ-024 Watchdog: a 16-bit counter clears on phase entry and increments each cycle the phase stays active.
REQ-025 If the watchdog counter reaches TIMEOUT-1 without phase_done[cstate], then on the next cycle cstate=0, busy=0, err=1, and done stays 0.
REQ-026 If phase_done[cstate] and the timeout condition occur in the same cycle, phase_done wins.
REQ-027 err remains 1 until the next accepted start, which clears it in the same cycle that cstate becomes 1.
REQ-028 abort=1 while busy=1 produces, at the next cycle, cstate=0 and busy=0, with done=0, err unchanged, and no phase_start.
REQ-029 abort has priority over phase_done and over the timeout in the same cycle.
REQ-030 abort=1 while busy=0 has no effect; abort and start asserted together while idle means start is accepted.

Reset
REQ-031 While rst_n=0, all outputs are 0: cstate=IDLE, mux_enc_dec=ENC, phase_start=0, busy=0, done=0, err=0; the watchdog counter is cleared.
REQ-032 Reset asserted mid-operation forces the idle values immediately, without waiting for clk; no done pulse is produced.
REQ-033 After rst_n deasserts, the first start is accepted normally.

Verification
REQ-034 DEC run: start=1, enc_dec_sel=1, each unit returns done 3 cycles after its start -> cstate steps 1,2,3,4,5,6,7,0; 7 single phase_start pulses; done pulse exactly 29 cycles after start.
REQ-035 ENC run: enc_dec_sel=0, immediate done (second cycle of each phase) -> cstate steps 1,9,2,3,4,8,10,6,11,0; mux_enc_dec=0 throughout.
REQ-036 Timeout: TIMEOUT=16, NTT never done -> cstate=0 and err=1 exactly 17 cycles after NTT entry, done=0; a new start then clears err.
REQ-037 Boundary events: wrong-index done, done on the entry cycle, start while busy, and done coincident with the final watchdog cycle -> the first three are ignored and the last advances the phase.
REQ-038 Abort and reset: abort during PAcc -> idle next cycle, done=0; rst_n pulsed low mid-INTT -> all outputs 0 asynchronously.
